// File: rtl/shift_sequencer_if.sv
// Request/Shifter/result bundle for shift_sequencer.
// Carries ROT only when SHIFT_SEQ_ROTATE_EN is defined.
interface shift_sequencer_if #(
  parameter int WIDTH = 16,
  parameter int AMT_W = 4
);
  logic             START;
  logic [1:0]       OP;
  logic [AMT_W-1:0] AMT;
  logic [WIDTH-1:0] B_IN;
`ifdef SHIFT_SEQ_ROTATE_EN
  logic             ROT;
`endif
  logic [1:0]       S_SHF;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] H;
  logic             READY;
  logic             DONE;
  logic [WIDTH-1:0] RESULT;
  logic             C_OUT;
  logic             N_OUT;
  logic             Z_OUT;

  // master: requester plus the combinational Shifter returning H
  modport master (
`ifdef SHIFT_SEQ_ROTATE_EN
    output ROT,
`endif
    output START, OP, AMT, B_IN, H,
    input  S_SHF, B, READY, DONE, RESULT, C_OUT, N_OUT, Z_OUT
  );

  modport slave (
`ifdef SHIFT_SEQ_ROTATE_EN
    input  ROT,
`endif
    input  START, OP, AMT, B_IN, H,
    output S_SHF, B, READY, DONE, RESULT, C_OUT, N_OUT, Z_OUT
  );
endinterface

// File: rtl/shift_sequencer.sv
// Multi-cycle controller feeding a 1-bit-per-cycle Shifter, START/READY/DONE handshake.
// Optional rotate support (ROT input) is enabled by defining SHIFT_SEQ_ROTATE_EN.
module shift_sequencer #(
  parameter int WIDTH = 16,
  parameter int AMT_W = 4
) (
  input  logic            CLK,
  input  logic            RESET,
  shift_sequencer_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SHIFT, FINISH} state_t;

  localparam logic [1:0] OP_PASS = 2'b00;
  localparam logic [1:0] OP_SHL  = 2'b01;
  localparam logic [1:0] OP_SHR  = 2'b10;

  state_t           state;
  logic [1:0]       op_q;
  logic [AMT_W-1:0] cnt;
  logic [WIDTH-1:0] work;
  logic [1:0]       s_shf;
  logic             ready;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             c_out;
  logic             n_out;
  logic             z_out;
`ifdef SHIFT_SEQ_ROTATE_EN
  logic             rot_q;
`endif

  logic [WIDTH-1:0] next_work;
  logic             edge_bit;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    next_work = bus.H;
    edge_bit  = (op_q == OP_SHL) ? work[WIDTH-1] : work[0];
`ifdef SHIFT_SEQ_ROTATE_EN
    if (rot_q && op_q == OP_SHL)
      next_work[0] = work[WIDTH-1];
    else if (rot_q && op_q == OP_SHR)
      next_work[WIDTH-1] = work[0];
`endif
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state  <= IDLE;
      op_q   <= OP_PASS;
      cnt    <= '0;
      work   <= '0;
      s_shf  <= OP_PASS;
      ready  <= 1'b1;
      done   <= 1'b0;
      result <= '0;
      c_out  <= 1'b0;
      n_out  <= 1'b0;
      z_out  <= 1'b1;
`ifdef SHIFT_SEQ_ROTATE_EN
      rot_q  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.START) begin
            op_q  <= bus.OP;
            cnt   <= bus.AMT;
            work  <= bus.B_IN;
            ready <= 1'b0;
`ifdef SHIFT_SEQ_ROTATE_EN
            rot_q <= bus.ROT;
`endif
            if (bus.AMT == '0 || bus.OP == OP_PASS) begin
              state  <= FINISH;
              done   <= 1'b1;
              result <= bus.B_IN;
              c_out  <= 1'b0;
              n_out  <= bus.B_IN[WIDTH-1];
              z_out  <= (bus.B_IN == '0);
            end else begin
              state <= SHIFT;
              s_shf <= bus.OP;
            end
          end
        end

        SHIFT: begin
          work <= next_work;
          cnt  <= cnt - 1'b1;
          // Results are taken from the final shift's combinational values so they line up with DONE.
          if (cnt == AMT_W'(1)) begin
            state  <= FINISH;
            s_shf  <= OP_PASS;
            done   <= 1'b1;
            result <= next_work;
            c_out  <= edge_bit;
            n_out  <= next_work[WIDTH-1];
            z_out  <= (next_work == '0);
          end
        end

        FINISH: begin
          done  <= 1'b0;
          ready <= 1'b1;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.B      = (state == SHIFT) ? work : bus.B_IN;
  assign bus.S_SHF  = s_shf;
  assign bus.READY  = ready;
  assign bus.DONE   = done;
  assign bus.RESULT = result;
  assign bus.C_OUT  = c_out;
  assign bus.N_OUT  = n_out;
  assign bus.Z_OUT  = z_out;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer with a behavioural 1-bit Shifter on H.
// Rotate vectors are included when SHIFT_SEQ_ROTATE_EN is defined.
module tb_shift_sequencer;

  localparam int WIDTH = 16;
  localparam int AMT_W = 4;

  logic clk;
  logic rst;
  int   tests  = 0;
  int   failed = 0;

  shift_sequencer_if #(.WIDTH(WIDTH), .AMT_W(AMT_W)) bus ();

  shift_sequencer #(.WIDTH(WIDTH), .AMT_W(AMT_W)) dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Downstream Shifter: one bit per operation, selected by S_SHF.
  always_comb begin
    case (bus.S_SHF)
      2'b01:   bus.H = {bus.B[WIDTH-2:0], 1'b0};
      2'b10:   bus.H = {1'b0, bus.B[WIDTH-1:1]};
      2'b11:   bus.H = {bus.B[WIDTH-1], bus.B[WIDTH-1:1]};
      default: bus.H = bus.B;
    endcase
  end

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [3:0]  amt;
    logic [15:0] b_in;
    logic        rot;
    int          glitch;
    logic [15:0] exp_result;
    logic        exp_c;
    logic        exp_n;
    logic        exp_z;
    int          exp_lat;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input string name, input logic [1:0] op, input logic [3:0] amt,
                     input logic [15:0] b_in, input logic rot, input int glitch,
                     input logic [15:0] res, input logic c, input logic n, input logic z,
                     input int lat);
    vec_t v;
    v.name = name; v.op = op; v.amt = amt; v.b_in = b_in; v.rot = rot; v.glitch = glitch;
    v.exp_result = res; v.exp_c = c; v.exp_n = n; v.exp_z = z; v.exp_lat = lat;
    vecs.push_back(v);
  endtask

  task automatic drive_req(input logic start, input logic [1:0] op, input logic [3:0] amt,
                           input logic [15:0] b_in, input logic rot);
    bus.START = start;
    bus.OP    = op;
    bus.AMT   = amt;
    bus.B_IN  = b_in;
`ifdef SHIFT_SEQ_ROTATE_EN
    bus.ROT   = rot;
`else
    if (rot) begin end
`endif
  endtask

  // Cycle 0 is the accepting edge; latency counts edges up to and including the one raising DONE.
  task automatic run_op(input vec_t v);
    int   n;
    logic seen;
    n    = 0;
    seen = 1'b0;
    @(negedge clk);
    drive_req(1'b1, v.op, v.amt, v.b_in, v.rot);
    while (!seen && n < 40) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (n == v.glitch)
        drive_req(1'b1, 2'b10, 4'd1, 16'hFFFF, 1'b0);
      else
        drive_req(1'b0, 2'b00, 4'd0, 16'hAAAA, 1'b0);
      if (n == 1 && v.exp_lat > 1)
        check({v.name, " s_shf"}, 32'(bus.S_SHF), 32'(v.op));
      if (bus.DONE) seen = 1'b1;
    end
    drive_req(1'b0, 2'b00, 4'd0, 16'h0000, 1'b0);
    check({v.name, " done_seen"}, 32'(seen), 32'd1);
    check({v.name, " latency"}, 32'(n), 32'(v.exp_lat));
    check({v.name, " result"}, 32'(bus.RESULT), 32'(v.exp_result));
    check({v.name, " c_out"}, 32'(bus.C_OUT), 32'(v.exp_c));
    check({v.name, " n_out"}, 32'(bus.N_OUT), 32'(v.exp_n));
    check({v.name, " z_out"}, 32'(bus.Z_OUT), 32'(v.exp_z));
    check({v.name, " busy_at_done"}, 32'(bus.READY), 32'd0);
    @(posedge clk);
    @(negedge clk);
    check({v.name, " done_pulse"}, 32'(bus.DONE), 32'd0);
    check({v.name, " ready_after"}, 32'(bus.READY), 32'd1);
    check({v.name, " s_shf_idle"}, 32'(bus.S_SHF), 32'd0);
    check({v.name, " result_held"}, 32'(bus.RESULT), 32'(v.exp_result));
  endtask

  initial begin
    int   done_cnt;
    vec_t tail;

    //   name         op     amt    b_in      rot glitch result    c     n     z     lat
    add("shl4_glitch", 2'b01, 4'd4,  16'h0F0F, 0, 2, 16'hF0F0, 1'b0, 1'b1, 1'b0, 5);
    add("shr1",        2'b10, 4'd1,  16'h0001, 0, 0, 16'h0000, 1'b1, 1'b0, 1'b1, 2);
    add("asr15",       2'b11, 4'd15, 16'h8000, 0, 0, 16'hFFFF, 1'b0, 1'b1, 1'b0, 16);
    add("amt0",        2'b01, 4'd0,  16'h1234, 0, 0, 16'h1234, 1'b0, 1'b0, 1'b0, 1);
    add("pass",        2'b00, 4'd5,  16'h8001, 0, 0, 16'h8001, 1'b0, 1'b1, 1'b0, 1);
    add("shl15",       2'b01, 4'd15, 16'h0003, 0, 0, 16'h8000, 1'b1, 1'b1, 1'b0, 16);
    add("asr2",        2'b11, 4'd2,  16'hF00E, 0, 0, 16'hFC03, 1'b1, 1'b1, 1'b0, 3);
`ifdef SHIFT_SEQ_ROTATE_EN
    add("rotl4",       2'b01, 4'd4,  16'h8421, 1, 0, 16'h4218, 1'b0, 1'b0, 1'b0, 5);
    add("rotr4",       2'b10, 4'd4,  16'h8421, 1, 0, 16'h1842, 1'b0, 1'b0, 1'b0, 5);
    add("rotr1",       2'b10, 4'd1,  16'h0001, 1, 0, 16'h8000, 1'b1, 1'b1, 1'b0, 2);
    add("asr_rot",     2'b11, 4'd2,  16'hF00E, 1, 0, 16'hFC03, 1'b1, 1'b1, 1'b0, 3);
`endif

    rst = 1'b1;
    drive_req(1'b0, 2'b00, 4'd0, 16'h0000, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset ready",  32'(bus.READY),  32'd1);
    check("reset done",   32'(bus.DONE),   32'd0);
    check("reset result", 32'(bus.RESULT), 32'h0);
    check("reset z_out",  32'(bus.Z_OUT),  32'd1);
    check("reset n_out",  32'(bus.N_OUT),  32'd0);
    check("reset c_out",  32'(bus.C_OUT),  32'd0);
    check("reset s_shf",  32'(bus.S_SHF),  32'd0);

    for (int i = 0; i < vecs.size(); i++)
      run_op(vecs[i]);

    // Abort a long shift mid-flight; RESULT is nonzero beforehand.
    @(negedge clk);
    drive_req(1'b1, 2'b01, 4'd8, 16'h00FF, 1'b0);
    @(posedge clk);
    @(negedge clk);
    drive_req(1'b0, 2'b00, 4'd0, 16'h0000, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("abort ready",  32'(bus.READY),  32'd1);
    check("abort result", 32'(bus.RESULT), 32'h0);
    check("abort done",   32'(bus.DONE),   32'd0);
    check("abort z_out",  32'(bus.Z_OUT),  32'd1);
    check("abort s_shf",  32'(bus.S_SHF),  32'd0);
    @(negedge clk);
    rst = 1'b0;
    done_cnt = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.DONE) done_cnt++;
    end
    check("abort no_done", 32'(done_cnt), 32'd0);

    tail.name = "post_abort"; tail.op = 2'b10; tail.amt = 4'd2; tail.b_in = 16'h0008;
    tail.rot = 1'b0; tail.glitch = 0; tail.exp_result = 16'h0002; tail.exp_c = 1'b0;
    tail.exp_n = 1'b0; tail.exp_z = 1'b0; tail.exp_lat = 3;
    run_op(tail);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
